// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: turns the core's SRAM-style data port into single-beat AXI4 reads/writes,
// stalling the core until the response returns; one transaction outstanding at a time.
module sram_axi_bridge #(
   parameter logic [7:0] AXI_ID = 8'h00,
   parameter int         ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_en,
   input  logic              io_re,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [31:0]       io_din,
   input  logic [3:0]        io_wmask,
   output logic [31:0]       io_dout,
   output logic              io_stall,
   output logic              io_done,
   output logic              io_err,
   output logic [7:0]        ar_id,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   output logic [1:0]        ar_burst,
   output logic              ar_valid,
   input  logic              ar_ready,
   input  logic [7:0]        r_id,
   input  logic [31:0]       r_data,
   input  logic [1:0]        r_resp,
   input  logic              r_last,
   input  logic              r_valid,
   output logic              r_ready,
   output logic [7:0]        aw_id,
   output logic [ADDR_W-1:0] aw_addr,
   output logic [7:0]        aw_len,
   output logic [2:0]        aw_size,
   output logic [1:0]        aw_burst,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [31:0]       w_data,
   output logic [3:0]        w_strb,
   output logic              w_last,
   output logic              w_valid,
   input  logic              w_ready,
   input  logic [7:0]        b_id,
   input  logic [1:0]        b_resp,
   input  logic              b_valid,
   output logic              b_ready
);
   typedef enum logic [2:0] {IDLE, AR, R, AWW, B, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d, dout_q, dout_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [1:0]        resp_q, resp_d;
   logic              aw_done_q, aw_done_d, w_done_q, w_done_d, got_q, got_d;
   logic              unused_ids;

   assign unused_ids = ^{r_id, b_id};

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      wmask_d   = wmask_q;
      dout_d    = dout_q;
      resp_d    = resp_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      got_d     = got_q;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            got_d     = 1'b0;
            if (io_en & io_we) begin
               addr_d  = io_addr;
               din_d   = io_din;
               wmask_d = io_wmask;
               state_d = AWW;
            end else if (io_en & io_re) begin
               addr_d  = io_addr;
               state_d = AR;
            end
         end
         AR: state_d = ar_ready ? R : AR;
         // only the first beat is kept; surplus beats are drained until r_last
         R: if (r_valid) begin
            if (!got_q) begin
               dout_d = r_data;
               resp_d = r_resp;
               got_d  = 1'b1;
            end
            if (r_last) state_d = DONE;
         end
         AWW: begin
            aw_done_d = aw_done_q | aw_ready;
            w_done_d  = w_done_q | w_ready;
            if (aw_done_d & w_done_d) state_d = B;
         end
         B: if (b_valid) begin
            resp_d  = b_resp;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         din_q     <= '0;
         wmask_q   <= '0;
         dout_q    <= '0;
         resp_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         got_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         wmask_q   <= wmask_d;
         dout_q    <= dout_d;
         resp_q    <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         got_q     <= got_d;
      end
   end

   assign io_stall = io_en & (io_re | io_we) & ~io_done;
   assign io_done  = state_q == DONE;
   assign io_err   = io_done & (resp_q != 2'b00);
   assign io_dout  = dout_q;

   assign ar_id    = AXI_ID;
   assign ar_addr  = addr_q;
   assign ar_len   = 8'h00;
   assign ar_size  = 3'b010;
   assign ar_burst = 2'b01;
   assign ar_valid = state_q == AR;
   assign r_ready  = state_q == R;

   assign aw_id    = AXI_ID;
   assign aw_addr  = addr_q;
   assign aw_len   = 8'h00;
   assign aw_size  = 3'b010;
   assign aw_burst = 2'b01;
   assign aw_valid = (state_q == AWW) & ~aw_done_q;
   assign w_data   = din_q;
   assign w_strb   = wmask_q;
   assign w_last   = 1'b1;
   assign w_valid  = (state_q == AWW) & ~w_done_q;
   assign b_ready  = state_q == B;
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: drives core requests against a delay-configurable AXI responder;
// completions are checked against a scoreboard of expected {err, dout}.
module tb_sram_axi_bridge;
   logic        clk = 0, rst = 1;
   logic        io_en = 0, io_re = 0, io_we = 0;
   logic [31:0] io_addr = 0, io_din = 0, io_dout;
   logic [3:0]  io_wmask = 0;
   logic        io_stall, io_done, io_err;
   logic [7:0]  ar_id, ar_len, aw_id, aw_len, r_id, b_id;
   logic [31:0] ar_addr, aw_addr, r_data, w_data;
   logic [2:0]  ar_size, aw_size;
   logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
   logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
   logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [3:0]  w_strb;

   sram_axi_bridge dut (
      .clk(clk), .rst(rst), .io_en(io_en), .io_re(io_re), .io_we(io_we), .io_addr(io_addr),
      .io_din(io_din), .io_wmask(io_wmask), .io_dout(io_dout), .io_stall(io_stall),
      .io_done(io_done), .io_err(io_err),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .w_data(w_data), .w_strb(w_strb),
      .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [32:0] sb[$];
   int done_cnt = 0, req_cnt = 0;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, nbeats = 1;
   logic [31:0] rdata = 0, exp_addr = 0, exp_wdata = 0, last_rd = 0;
   logic [3:0]  exp_strb = 0;
   logic [1:0]  rresp = 0, bresp = 0;
   int ar_hs = 0, aw_hs = 0, w_hs = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // AXI responder: each channel raises its ready/valid after a configurable number of cycles
   initial begin
      int ar_c, r_c, aw_c, w_c, b_c, beat;
      logic r_pend, b_pend, aw_seen, w_seen, ar_wait;
      {ar_ready, r_valid, aw_ready, w_ready, b_valid, r_last} = '0;
      r_data = 0; r_resp = 0; b_resp = 0; r_id = 0; b_id = 0;
      {ar_c, r_c, aw_c, w_c, b_c, beat} = '0;
      {r_pend, b_pend, aw_seen, w_seen, ar_wait} = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            {ar_ready, r_valid, aw_ready, w_ready, b_valid, r_last} = '0;
            {ar_c, r_c, aw_c, w_c, b_c, beat} = '0;
            {r_pend, b_pend, aw_seen, w_seen, ar_wait} = '0;
            continue;
         end
         if (ar_ready) begin
            ar_ready = 0; ar_c = 0; ar_hs++; ar_wait = 0;
            r_pend = 1; r_c = 0; beat = 0;
         end else if (ar_valid) begin
            ar_wait = 1;
            chk("ar_fields", {ar_addr, ar_id, ar_len, ar_size, ar_burst},
                {exp_addr, 8'h00, 8'h00, 3'b010, 2'b01});
            if (ar_c == ar_dly) ar_ready = 1; else ar_c++;
         end else if (ar_wait) begin
            chk("ar_hold", ar_valid, 1'b1);
            ar_wait = 0;
         end
         if (r_valid) begin
            beat++;
            if (beat == nbeats) begin
               r_valid = 0; r_last = 0; r_pend = 0;
            end else begin
               r_data = 32'hDEAD0000 + 32'(beat);
               r_resp = 2'b11;
               r_last = (beat == nbeats - 1);
            end
         end else if (r_pend) begin
            if (r_c == r_dly) begin
               chk("r_ready", r_ready, 1'b1);
               r_valid = 1; r_data = rdata; r_resp = rresp; r_last = (nbeats == 1);
            end else r_c++;
         end
         if (aw_ready) begin
            aw_ready = 0; aw_c = 0; aw_hs++; aw_seen = 1;
         end else if (aw_valid) begin
            chk("aw_fields", {aw_addr, aw_id, aw_len, aw_size, aw_burst},
                {exp_addr, 8'h00, 8'h00, 3'b010, 2'b01});
            if (aw_c == aw_dly) aw_ready = 1; else aw_c++;
         end
         if (w_ready) begin
            w_ready = 0; w_c = 0; w_hs++; w_seen = 1;
         end else if (w_valid) begin
            chk("w_fields", {w_data, w_strb, w_last}, {exp_wdata, exp_strb, 1'b1});
            if (w_c == w_dly) w_ready = 1; else w_c++;
         end
         if (w_seen && !aw_seen) chk("w_drop_aw_hold", {w_valid, aw_valid, b_ready}, 3'b010);
         if (aw_seen && w_seen) begin
            aw_seen = 0; w_seen = 0; b_pend = 1; b_c = 0;
         end
         if (b_valid) begin
            b_valid = 0; b_pend = 0;
         end else if (b_pend) begin
            if (b_c == b_dly) begin
               chk("b_ready", b_ready, 1'b1);
               b_valid = 1; b_resp = bresp;
            end else b_c++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && io_done) begin
         done_cnt++;
         chk("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("io_dout", io_dout, e[31:0]);
            chk("io_err", io_err, e[32]);
         end
      end
   end

   task automatic req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] exp_d, input logic exp_e, input int lat);
      int n;
      logic stall_ok;
      n = 0; stall_ok = 1;
      exp_addr = a; exp_wdata = d; exp_strb = m;
      sb.push_back({exp_e, exp_d});
      req_cnt++;
      @(posedge clk); #1;
      io_en = 1; io_we = we; io_re = re; io_addr = a; io_din = d; io_wmask = m;
      while (n < 200) begin
         @(negedge clk);
         if (io_done) break;
         stall_ok &= io_stall;
         if (n == 1) begin
            io_addr = ~a; io_din = ~d; io_wmask = ~m;
         end
         n++;
      end
      chk("done_seen", io_done, 1'b1);
      if (lat >= 0) chk("latency", n, lat);
      chk("stall_held", stall_ok, 1'b1);
      chk("stall_done", io_stall, 1'b0);
      @(posedge clk); #1;
      io_en = 0; io_we = 0; io_re = 0;
      @(negedge clk);
      chk("done_pulse", io_done, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outs", {ar_valid, r_ready, aw_valid, w_valid, b_ready, io_done, io_err}, 7'b0);
      chk("rst_dout", io_dout, 32'h0);
      rst = 0;
      // basic read and write, everything ready immediately
      rdata = 32'h41;
      req(0, 1, 32'hBFD003F8, 32'h0, 4'h0, 32'h41, 0, 3);
      last_rd = 32'h41;
      req(1, 0, 32'hBFD003F8, 32'h55, 4'b0001, last_rd, 0, 3);
      // write data accepted three cycles before address
      aw_dly = 3;
      req(1, 1, 32'h10000004, 32'h12345678, 4'b1111, last_rd, 0, 6);
      aw_dly = 0;
      // slow read
      ar_dly = 5; r_dly = 7; rdata = 32'hCAFEF00D;
      req(0, 1, 32'h20000010, 32'h0, 4'h0, rdata, 0, 15);
      last_rd = rdata; ar_dly = 0; r_dly = 0;
      // extra beats drained, first beat kept
      nbeats = 3; rdata = 32'h0BADBEEF;
      req(0, 1, 32'h20000020, 32'h0, 4'h0, rdata, 0, 5);
      last_rd = rdata; nbeats = 1;
      // error responses
      bresp = 2'b10;
      req(1, 0, 32'h30000000, 32'hA5A5A5A5, 4'b0110, last_rd, 1, 3);
      bresp = 2'b00; rdata = 32'h00000077;
      req(0, 1, 32'h30000004, 32'h0, 4'h0, rdata, 0, 3);
      rresp = 2'b10; rdata = 32'h00000088;
      req(0, 1, 32'h30000008, 32'h0, 4'h0, rdata, 1, 3);
      rresp = 2'b00;
      // reset while waiting for read data
      r_dly = 10; exp_addr = 32'h40000000;
      @(posedge clk); #1;
      io_en = 1; io_re = 1; io_addr = 32'h40000000;
      repeat (3) @(negedge clk);
      chk("in_r", r_ready, 1'b1);
      #2 rst = 1;
      #1;
      chk("rst_async", {ar_valid, r_ready, aw_valid, w_valid, b_ready, io_done, io_err}, 7'b0);
      chk("rst_async_dout", io_dout, 32'h0);
      io_en = 0; io_re = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      r_dly = 0; rdata = 32'h13572468;
      req(0, 1, 32'h40000004, 32'h0, 4'h0, rdata, 0, 3);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, req_cnt);
      chk("sb_drained", sb.size(), 0);
      chk("ar_beats", ar_hs, 7);
      chk("aw_beats", aw_hs, 3);
      chk("w_beats", w_hs, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
